exec_alu: RTL
=============

EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port Clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port InValid, input, 1, operation offered this cycle.
REQ-005 SHALL have port InReady, output, 1, unit can accept an operation this cycle.
REQ-006 SHALL have port ALUControl, input, 6, operation code from the ALU control stage.
REQ-007 SHALL have port A, input, 32, operand rs.
REQ-008 SHALL have port B, input, 32, operand rt or sign-extended immediate.
REQ-009 SHALL have port Shamt, input, 5, shift amount for SLL/SRL.
REQ-010 SHALL have port ALUResult, output, 32, registered result.
REQ-011 SHALL have port Zero, output, 1, registered (ALUResult == 0).
REQ-012 SHALL have port OutValid, output, 1, one-cycle pulse marking a new ALUResult.
REQ-013 SHALL have port BadOp, output, 1, registered flag set with OutValid for an unknown code.

Function
REQ-014 SHALL accept an operation on a rising edge where InValid=1 and InReady=1; otherwise InValid SHALL be ignored and nothing latched.
REQ-015 SHALL drive InReady=1 exactly when the FSM is IDLE.
REQ-016 SHALL implement FSM states IDLE and MUL; IDLE->MUL on acceptance of code 011000; MUL->IDLE on the fourth MUL-state edge; all other accepts stay IDLE.
REQ-017 SHALL, for non-MUL codes, register result, Zero, BadOp and OutValid=1 on the acceptance edge (latency 1).
REQ-018 SHALL decode 100000 ADD (A+B, wrap), 100010 SUB (A-B, wrap), 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000000 SLL (B<<Shamt), 000010 SRL (B>>Shamt logical), 101010 SLT (signed A<B ? 1 : 0).
REQ-019 SHALL produce no overflow exception; ADD/SUB results are the low 32 bits.
REQ-020 SHALL treat any other code as BadOp: ALUResult=0, Zero=1, BadOp=1, OutValid=1, latency 1.
REQ-021 SHALL, for MUL, latch A and B and clear the accumulator and a 2-bit count on the acceptance edge.
REQ-022 SHALL, on each MUL-state edge k=0..3, add (A * B[8k+7:8k]) << 8k to the 32-bit accumulator, discarding bits above 31.
REQ-023 SHALL, on the k=3 edge, register the accumulator sum into ALUResult with Zero and OutValid=1 (accept-to-OutValid latency 5 edges, InReady low 4 cycles).
REQ-024 SHALL produce the low 32 bits of A*B, identical for signed and unsigned operands.
REQ-025 SHALL deassert OutValid on every edge that does not produce a result.
REQ-026 SHALL hold ALUResult, Zero and BadOp unchanged between results.
REQ-027 SHALL accept a new operation on the edge immediately after MUL returns to IDLE (back-to-back allowed).

Reset
REQ-028 SHALL, on Rst=0, immediately force IDLE, InReady=1 after release, ALUResult=0, Zero=0, OutValid=0, BadOp=0, accumulator and count=0.
REQ-029 SHALL abort an in-flight MUL on reset with no OutValid pulse afterwards.
REQ-030 SHALL not accept an operation on the first edge coincident with reset assertion.

Structure
REQ-031 SHALL take the ten operation-code constants and the FSM state encoding from shared package alu_pkg, also used by the ALU control stage.
REQ-032 SHALL place the 32x8 partial-product and accumulate datapath in one sub-module, exec_mul8.

Verification
REQ-033 SHALL cover ADD A=0x7FFFFFFF, B=1 -> next cycle ALUResult=0x80000000, Zero=0, OutValid pulse.
REQ-034 SHALL cover SUB A=B=0x1234 -> ALUResult=0, Zero=1; SLT A=0xFFFFFFFF, B=1 -> ALUResult=1.
REQ-035 SHALL cover MUL A=0xFFFFFFFF, B=3 -> InReady low 4 cycles, then ALUResult=0xFFFFFFFD, OutValid after 5 edges.
REQ-036 SHALL cover InValid held high with ADD during MUL -> ignored; ADD accepted on first IDLE edge, result one cycle after MUL result.
REQ-037 SHALL cover SLL B=1, Shamt=31 -> 0x80000000; SRL B=0x80000000, Shamt=31 -> 1.
REQ-038 SHALL cover code 111111 -> BadOp=1, ALUResult=0; reset asserted mid-MUL -> no OutValid, outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the ALU control stage and the execute ALU.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SLT = 6'b101010;
  localparam logic [5:0] OP_MUL = 6'b011000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  // Index of the final byte-slice step of a multiply.
  localparam logic [1:0] MUL_LAST_STEP = 2'd3;

endpackage

// File: rtl/exec_mul8.sv
// Iterative 32x8 partial-product multiplier: one byte of B per step, low DATA_W bits kept.
module exec_mul8 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [DATA_W-1:0] acc_p1;
  logic [7:0]        b_byte;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] pp;

  // Operand capture stage
  always_ff @(posedge clk) begin
    if (start) begin
      a_p0 <= a;
      b_p0 <= b;
    end
  end

  // Truncating products is safe: only the low DATA_W bits of A*B survive anyway.
  assign b_byte = b_p0[{count, 3'b000} +: 8];
  assign prod   = a_p0 * {{(DATA_W-8){1'b0}}, b_byte};
  assign pp     = prod << {count, 3'b000};
  assign sum    = acc_p1 + pp;

  // Accumulate stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
      count  <= 2'd0;
    end else if (start) begin
      acc_p1 <= '0;
      count  <= 2'd0;
    end else if (step) begin
      acc_p1 <= sum;
      count  <= count + 2'd1;
    end
  end

endmodule

// File: rtl/exec_alu.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a 4-step iterative multiply.
module exec_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [5:0]        ALUControl,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [4:0]        Shamt,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic              OutValid,
  output logic              BadOp
);

  alu_state_t        state;
  logic              accept;
  logic              mul_start;
  logic              mul_step;
  logic [1:0]        mul_count;
  logic [DATA_W-1:0] mul_sum;
  logic [DATA_W-1:0] comb_res;
  logic              comb_bad;

  function automatic logic [DATA_W:0] alu_eval(
    input logic [5:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [4:0]               sh
  );
    logic [DATA_W-1:0] res;
    logic              bad;
    res = '0;
    bad = 1'b0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_SLL:  res = $unsigned(b) << sh;
      OP_SRL:  res = $unsigned(b) >> sh;
      OP_SLT:  res = {{(DATA_W-1){1'b0}}, (a < b)};
      default: bad = 1'b1;
    endcase
    return {bad, res};
  endfunction

  assign InReady   = (state == ST_IDLE);
  assign accept    = InValid && InReady;
  assign mul_start = accept && (ALUControl == OP_MUL);
  assign mul_step  = (state == ST_MUL);
  assign {comb_bad, comb_res} = alu_eval(ALUControl, A, B, Shamt);

  exec_mul8 #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk   (Clk),
    .rst_n (Rst),
    .start (mul_start),
    .step  (mul_step),
    .a     (A),
    .b     (B),
    .count (mul_count),
    .sum   (mul_sum)
  );

  // Result stage
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      ALUResult <= '0;
      Zero      <= 1'b0;
      OutValid  <= 1'b0;
      BadOp     <= 1'b0;
    end else begin
      OutValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (ALUControl == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              ALUResult <= comb_res;
              Zero      <= (comb_res == '0);
              BadOp     <= comb_bad;
              OutValid  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_count == MUL_LAST_STEP) begin
            ALUResult <= mul_sum;
            Zero      <= (mul_sum == '0);
            BadOp     <= 1'b0;
            OutValid  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
